// File: rtl/morse_ram_scheduler_pkg.sv
// Shared constants for the morse RAM scheduler: FSM encodings, requester ids, default widths.
// Used by both the top and the arbiter; see SCHED_RR_EN in the arbiter for grant policy.
package morse_ram_scheduler_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] REQ_P1 = 2'd0;
    localparam logic [1:0] REQ_P2 = 2'd1;
    localparam logic [1:0] REQ_RP = 2'd2;

    // Requester following id in the player1 -> player2 -> translator ring.
    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == REQ_RP) ? REQ_P1 : id + 2'd1;
    endfunction

endpackage

// File: rtl/morse_ram_scheduler_arb3_rr.sv
// Three-way arbiter returning a 2-bit requester id. With SCHED_RR_EN defined it is round-robin
// (pointer moves past whoever was last served); otherwise fixed priority player1 > player2 > translator.
module arb3_rr
    import morse_ram_scheduler_pkg::*;
(
`ifdef SCHED_RR_EN
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       upd_i,
    input  logic [1:0] upd_id_i,
`endif
    input  logic [2:0] req_i,
    output logic       any_o,
    output logic [1:0] id_o
);

    assign any_o = |req_i;

`ifdef SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;
    logic       found;

    always_comb begin
        id_o  = REQ_P1;
        found = 1'b0;
        cand  = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_i[cand]) begin
                id_o  = cand;
                found = 1'b1;
            end
            cand = next_id(cand);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) ptr_d = next_id(upd_id_i);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) ptr_q <= REQ_P1;
        else           ptr_q <= ptr_d;
    end
`else
    always_comb begin
        if (req_i[0])      id_o = REQ_P1;
        else if (req_i[1]) id_o = REQ_P2;
        else               id_o = REQ_RP;
    end
`endif

endmodule

// File: rtl/morse_ram_scheduler.sv
// Single owner of the morse-code RAM: serialises player1 appends, player2 sequential reads and
// translator replays through one IDLE/ISSUE/WAIT/RESP sequence. Grant policy set by SCHED_RR_EN.
module morse_ram_scheduler
    import morse_ram_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
)(
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              clear_i,
    input  logic              wr_req_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic              wr_full_o,
    input  logic              rd_req_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_empty_o,
    input  logic              rp_req_i,
    input  logic [ADDR_W-1:0] rp_addr_i,
    output logic [DATA_W-1:0] rp_data_o,
    output logic              rp_valid_o,
    output logic [ADDR_W:0]   count_o,
    output logic [ADDR_W:0]   rd_ptr_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_wren_o,
    input  logic [DATA_W-1:0] ram_q_i
);

    localparam logic [ADDR_W:0] CAP       = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q;
    logic [1:0]        wait_q;
    logic              refuse_q;
    logic [ADDR_W:0]   count_q, rd_ptr_q;
    logic [ADDR_W-1:0] ram_addr_q, addr_sel;
    logic [DATA_W-1:0] ram_data_q, rd_data_q, rp_data_q;
    logic              ram_wren_q;

    logic       arb_any;
    logic [1:0] arb_id;
    logic       gnt_refuse;
    logic       resp_fire;

    assign resp_fire = (state_q == S_RESP) && !clear_i;

`ifdef SCHED_RR_EN
    arb3_rr u_arb (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .upd_i    (resp_fire),
        .upd_id_i (gnt_q),
        .req_i    ({rp_req_i, rd_req_i, wr_req_i}),
        .any_o    (arb_any),
        .id_o     (arb_id)
    );
`else
    arb3_rr u_arb (
        .req_i    ({rp_req_i, rd_req_i, wr_req_i}),
        .any_o    (arb_any),
        .id_o     (arb_id)
    );
`endif

    // Refusals skip the RAM entirely and answer on the following cycle.
    assign gnt_refuse = ((arb_id == REQ_P1) && (count_q == CAP)) ||
                        ((arb_id == REQ_P2) && (rd_ptr_q == count_q));

    always_comb begin
        case (arb_id)
            REQ_P1:  addr_sel = count_q[ADDR_W-1:0];
            REQ_P2:  addr_sel = rd_ptr_q[ADDR_W-1:0];
            default: addr_sel = rp_addr_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_any) state_d = gnt_refuse ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = (RD_LAT > 1) ? S_WAIT : S_RESP;
            S_WAIT:  if (wait_q == 2'd0) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) state_d = S_IDLE;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            gnt_q      <= REQ_P1;
            wait_q     <= 2'd0;
            refuse_q   <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            rd_data_q  <= '0;
            rp_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ram_wren_q <= 1'b0;
            if (clear_i) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: if (arb_any) begin
                        gnt_q    <= arb_id;
                        refuse_q <= gnt_refuse;
                        if (!gnt_refuse) begin
                            ram_addr_q <= addr_sel;
                            if (arb_id == REQ_P1) begin
                                ram_data_q <= wr_data_i;
                                ram_wren_q <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: wait_q <= WAIT_INIT;
                    S_WAIT:  wait_q <= wait_q - 2'd1;
                    default: begin
                        if (refuse_q) begin
                            if (gnt_q == REQ_P2) rd_data_q <= '0;
                        end else begin
                            case (gnt_q)
                                REQ_P1: count_q <= count_q + 1'b1;
                                REQ_P2: begin
                                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                                    rd_data_q <= ram_q_i;
                                end
                                default: rp_data_q <= ram_q_i;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // Response pulses come straight from the RESP state so read data lines up with ram_q.
    assign wr_ack_o   = resp_fire && (gnt_q == REQ_P1);
    assign wr_full_o  = wr_ack_o && refuse_q;
    assign rd_valid_o = resp_fire && (gnt_q == REQ_P2);
    assign rd_empty_o = rd_valid_o && refuse_q;
    assign rp_valid_o = resp_fire && (gnt_q == REQ_RP);
    assign rd_data_o  = rd_valid_o ? (refuse_q ? '0 : ram_q_i) : rd_data_q;
    assign rp_data_o  = rp_valid_o ? ram_q_i : rp_data_q;

    assign count_o    = count_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign busy_o     = (state_q != S_IDLE);
    assign ram_addr_o = ram_addr_q;
    assign ram_data_o = ram_data_q;
    assign ram_wren_o = ram_wren_q;

endmodule
